// File: rtl/alu_8bit.sv
// alu_8bit: registered arithmetic/logic unit.
// Operands and opcode are sampled on every rising clk edge. Result and the
// C/Z/V/N flags are registered together and become visible one cycle later.
// There is no handshake: a new operation is accepted on every edge, and the
// outputs are held until the next edge overwrites all of them.
module alu_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] R,
    output logic             C,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int MSB = WIDTH - 1;

    // One extra bit on the adder/subtractor captures carry-out or borrow.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_z;
    logic             w_n;

    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic             r_z;
    logic             r_v;
    logic             r_n;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    // The top bit of the widened difference is set exactly when A < B unsigned.
    assign w_diff = {1'b0, A} - {1'b0, B};

    // Select the result, carry and overflow for the current opcode.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_SHL: begin
                w_res = {A[MSB-1:0], 1'b0};
                w_c   = A[MSB];
            end
            OP_SHR: begin
                w_res = {1'b0, A[MSB:1]};
                w_c   = A[0];
            end
            OP_NOT: w_res = ~A;
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    // Zero and negative always follow the freshly computed result.
    assign w_z = (w_res == '0);
    assign w_n = w_res[MSB];

    // Register result and flags together; reset wins over any sampled op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_v   <= 1'b0;
            r_n   <= 1'b0;
        end else begin
            r_res <= w_res;
            r_c   <= w_c;
            r_z   <= w_z;
            r_v   <= w_v;
            r_n   <= w_n;
        end
    end

    assign R = r_res;
    assign C = r_c;
    assign Z = r_z;
    assign V = r_v;
    assign N = r_n;

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and random checks of the registered 8-bit ALU.
// Expected {R,C,Z,V,N} words are pushed when inputs are driven and popped
// one edge later, sampled 1 time unit after the rising edge.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] sel;
    logic [7:0] R;
    logic       C;
    logic       Z;
    logic       V;
    logic       N;

    int total = 0;
    int bad   = 0;

    // Expected packed output word: {R[7:0], C, Z, V, N}.
    logic [11:0] exp_q[$];

    alu_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .sel (sel),
        .R   (R),
        .C   (C),
        .Z   (Z),
        .V   (V),
        .N   (N)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pk(input logic [7:0] r, input logic c, input logic z,
                                       input logic v, input logic n);
        return {r, c, z, v, n};
    endfunction

    // Independent reference: integer arithmetic and signed range checks.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
        int ai = a;
        int bi = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t;
        int st;
        logic [7:0] r = 8'h00;
        logic c = 1'b0;
        logic v = 1'b0;
        case (s)
            3'd0: begin
                t = ai + bi; r = t[7:0]; c = (t > 255);
                st = sa + sb; v = (st > 127) || (st < -128);
            end
            3'd1: begin
                t = ai - bi; r = t[7:0]; c = (ai < bi);
                st = sa - sb; v = (st > 127) || (st < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin t = (ai * 2) % 256; r = t[7:0]; c = (ai >= 128); end
            3'd6: begin t = ai / 2; r = t[7:0]; c = (ai % 2) == 1; end
            default: r = 8'hFF - a;
        endcase
        return pk(r, c, (r == 8'h00), v, (r >= 8'd128));
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                         input logic [11:0] e);
        A   = a;
        B   = b;
        sel = s;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(8'hFF, 8'hFF, 3'b000, pk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL reset_%0d: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
        rst = 1'b0;
        drive(8'hFF, 8'hFF, 3'b000, pk(8'd254, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        e = exp_q.pop_front();
        total++;
        if ({R, C, Z, V, N} !== e) begin
            bad++;
            $display("FAIL reset_release: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                     R, C, Z, V, N, e[11:4], e[3:0]);
        end
    endtask

    task automatic test_add();
        logic [7:0]  ta[3] = '{8'd20, 8'd200, 8'd100};
        logic [7:0]  tb[3] = '{8'd10, 8'd100, 8'd100};
        logic [11:0] te[3] = '{{8'd30, 4'b0000}, {8'd44, 4'b1000}, {8'd200, 4'b0011}};
        logic [11:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], 3'b000, te[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL add_%0d: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0]  ta[3] = '{8'd50, 8'd5, 8'd128};
        logic [7:0]  tb[3] = '{8'd50, 8'd10, 8'd1};
        logic [11:0] te[3] = '{{8'd0, 4'b0100}, {8'd251, 4'b1001}, {8'd127, 4'b0010}};
        logic [11:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], 3'b001, te[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL sub_%0d: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
    endtask

    task automatic test_logic();
        logic [7:0]  tb[4] = '{8'd5, 8'd5, 8'd5, 8'd3};
        logic [2:0]  ts[4] = '{3'b010, 3'b011, 3'b100, 3'b010};
        logic [11:0] te[4] = '{{8'd4, 4'b0000}, {8'd13, 4'b0000}, {8'd9, 4'b0000},
                               {8'd0, 4'b0100}};
        logic [11:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(8'd12, tb[i], ts[i], te[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL logic_%0d: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
    endtask

    task automatic test_shift_not();
        logic [7:0]  ta[3] = '{8'h81, 8'h81, 8'h0F};
        logic [2:0]  ts[3] = '{3'b101, 3'b110, 3'b111};
        logic [11:0] te[3] = '{{8'h02, 4'b1000}, {8'h40, 4'b1000}, {8'hF0, 4'b0001}};
        logic [11:0] e;
        logic [7:0]  rb;
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            drive(ta[i], rb, ts[i], te[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL shift_not_%0d: got R=%h CZVN=%b%b%b%b want R=%h CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta[5] = '{8'd20, 8'd12, 8'd5, 8'd1, 8'd12};
        logic [7:0]  tb[5] = '{8'd10, 8'd5, 8'd10, 8'd1, 8'd5};
        logic [2:0]  ts[5] = '{3'b000, 3'b010, 3'b001, 3'b000, 3'b010};
        logic        tr[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] te[5] = '{{8'd30, 4'b0000}, {8'd4, 4'b0000}, {8'd0, 4'b0000},
                               {8'd2, 4'b0000}, {8'd4, 4'b0000}};
        logic [11:0] e;
        for (int i = 0; i < 5; i++) begin
            rst = tr[i];
            drive(ta[i], tb[i], ts[i], te[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL b2b_%0d: got R=%0d CZVN=%b%b%b%b want R=%0d CZVN=%b",
                         i, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  s;
        logic [11:0] e;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            drive(a, b, s, model(a, b, s));
            step();
            e = exp_q.pop_front();
            total++;
            if ({R, C, Z, V, N} !== e) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h sel=%0d got R=%h CZVN=%b%b%b%b want R=%h CZVN=%b",
                         i, a, b, s, R, C, Z, V, N, e[11:4], e[3:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 8'hFF;
        B   = 8'hFF;
        sel = 3'b000;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift_not();
        test_back_to_back();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Registered 8-bit arithmetic/logic unit with a 3-bit opcode select and four status flags: carry/borrow C, zero Z, signed overflow V, negative N.
- Used as the datapath execution element. Operands and opcode are sampled on each rising clock edge, and result and flags appear registered one cycle later.
- Purely single-cycle throughput: a new operation is accepted every cycle, with no handshake.

Parameters:
- WIDTH, 8, operand/result width. The spec values below assume 8; flags are derived from bit WIDTH-1 and the WIDTH-th carry bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- A    input  8  operand A (unsigned or two's complement, per op)
- B    input  8  operand B
- sel  input  3  operation select
- R    output 8  registered result
- C    output 1  registered carry (ADD), borrow (SUB) or shifted-out bit (shifts)
- Z    output 1  registered zero flag
- V    output 1  registered signed-overflow flag
- N    output 1  registered negative flag

Behaviour:
- Interface: one clock domain (clk). Reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, R=8'h00, C=0, Z=0, V=0, N=0. Reset has priority over any operation sampled in the same edge.
- Timing: combinational compute from A, B, sel. All outputs are registered together.
- Latency is 1 cycle: inputs present before edge k give R/flags valid after edge k. Outputs hold until the next edge.
- No combinational path from inputs to outputs.
- Opcodes (sel):
  - 000 ADD: {C,R} = A + B (9-bit sum). V = (A[7]==B[7]) && (R[7]!=A[7]).
  - 001 SUB: R = A - B mod 256. C = 1 when A < B unsigned (borrow). V = (A[7]!=B[7]) && (R[7]!=A[7]).
  - 010 AND: R = A & B; C=0, V=0.
  - 011 OR: R = A | B; C=0, V=0.
  - 100 XOR: R = A ^ B; C=0, V=0.
  - 101 SHL: R = {A[6:0],1'b0}; C = A[7]; V=0. B is ignored.
  - 110 SHR (logical): R = {1'b0,A[7:1]}; C = A[0]; V=0. B is ignored.
  - 111 NOT: R = ~A; C=0, V=0. B is ignored.
- Flags for every opcode: Z = (R == 8'h00); N = R[7]. Both are computed from the new result in the same cycle.
- Wrap-around: ADD and SUB results are truncated to 8 bits; no saturation.
- No sticky flags: every cycle fully overwrites all flags.
- Reset mid-stream: an operation sampled on a reset edge is discarded. The first post-reset result appears one cycle after the first non-reset edge.
- Outputs are never X after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=8'hFF, B=8'hFF, sel=000 -> R=0, C=0, Z=0, V=0, N=0. Release rst; the next edge gives R=254, C=1, Z=0, V=0, N=1.
- ADD:
  - A=20, B=10, sel=000 -> R=30, C=0, Z=0, V=0, N=0.
  - A=200, B=100 -> R=44, C=1, V=0, N=0.
  - A=100, B=100 -> R=200, C=0, V=1, N=1.
- SUB:
  - A=50, B=50, sel=001 -> R=0, C=0, Z=1, V=0, N=0.
  - A=5, B=10 -> R=251, C=1, Z=0, V=0, N=1.
  - A=128, B=1 -> R=127, C=0, V=1, N=0.
- Logic with A=12, B=5:
  - sel=010 -> R=4.
  - sel=011 -> R=13.
  - sel=100 -> R=9.
  - All three give C=0, V=0, Z=0, N=0.
  - A=12, B=3, sel=010 -> R=0, Z=1.
- Shift/NOT:
  - A=8'h81, sel=101 -> R=8'h02, C=1.
  - A=8'h81, sel=110 -> R=8'h40, C=1.
  - A=8'h0F, sel=111 -> R=8'hF0, N=1, C=0.
- Back-to-back and latency: change ops every cycle (ADD 20+10, then AND 12&5, then SUB 5-10) -> R sequence 30, 4, 251 on consecutive cycles, each exactly one edge after its inputs. Assert rst during the third op -> outputs cleared and that op's result is dropped.
